reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//   16-entry register file with 2 read ports and 1 write port, plus a pending-write scoreboard.
//   Sits downstream of the 4:16 read/write ID decoders and consumes their one-hot wordlines
//   (instantiated internally, one per port). It returns operand data to decode and flags RAW hazards
//   against in-flight producers, so the pipeline stall logic can hold issue.
// PARAMETERS
//   DATA_W       16  register width in bits
//   ZERO_REG_EN  1   1: R0 reads 0, ignores writes, is never pending; 0: R0 is an ordinary register
// PORTS
//   clk          in   1       rising-edge clock
//   rst_n        in   1       asynchronous active-low reset
//   src_id1      in   4       read port 1 register ID
//   src_id2      in   4       read port 2 register ID
//   wr_en        in   1       write-back strobe
//   wr_id        in   4       write-back register ID
//   wr_data      in   DATA_W  write-back data
//   pend_set     in   1       issue strobe; marks pend_id as awaiting write-back
//   pend_id      in   4       destination ID of the issuing instruction
//   src_data1    out  DATA_W  read port 1 data (combinational)
//   src_data2    out  DATA_W  read port 2 data (combinational)
//   src_busy1    out  1       src_id1 has an outstanding producer
//   src_busy2    out  1       src_id2 has an outstanding producer
//   pend_cnt     out  5       number of registers currently pending (0..16)
// BEHAVIOUR
//   Reset (rst_n=0, async): all 16 registers <= 0, pending[15:0] <= 0, pend_cnt <= 0.
//     Outputs are then combinational on zeroed state: src_data* = 0, src_busy* = 0.
//   Write: at posedge clk with wr_en=1, reg[wr_id] <= wr_data; pending[wr_id] is cleared.
//     When ZERO_REG_EN=1 and wr_id=0, the write is dropped.
//   Read: src_data* = OR over i of (wordline[i] & reg[i]), where wordline is the one-hot decode
//     of the source ID. Zero latency.
//   Bypass: if wr_en=1 & wr_id==src_idN & write not dropped, src_dataN = wr_data in the same cycle.
//   R0 (ZERO_REG_EN=1): src_dataN = 0 whenever src_idN=0, regardless of bypass.
//   Scoreboard: at posedge with pend_set=1, pending[pend_id] <= 1. pend_id=0 is ignored when
//     ZERO_REG_EN=1.
//   Same-edge set and clear on the same ID: set wins, because the new producer supersedes; pending stays 1.
//   Clear of a non-pending register: no effect on pending, no change to pend_cnt.
//   src_busyN = pending[src_idN] & ~(wr_en & wr_id==src_idN). The bypassed value resolves the
//     hazard that cycle.
//   pend_cnt: registered; always equals popcount(pending). Per edge it does +1 (set of a clear bit),
//     -1 (clear of a set bit), or net 0 (both, or neither effective). Never wraps; 16 is the maximum.
//   Both read ports may name the same register; the results are identical.
//   Reset asserted mid-operation discards all in-flight pending state immediately.
// TESTING
//   1. Reset, then read R1..R15 -> every src_data = 0, src_busy = 0, pend_cnt = 0.
//   2. Write R5=0xBEEF, next cycle src_id1=5 -> src_data1 = 0xBEEF.
//      Same-cycle wr R7=0x1234 with src_id2=7 -> src_data2 = 0x1234.
//   3. Write R0=0xFFFF (ZERO_REG_EN=1), read R0 -> 0x0000.
//      pend_set with pend_id=0 -> pend_cnt stays 0.
//   4. pend_set R3 -> next cycle src_busy1=1 (src_id1=3), pend_cnt=1.
//      wr R3=0x00AA same cycle -> src_busy1=0, src_data1=0x00AA; next cycle pend_cnt=0.
//   5. R9 pending; on one edge pend_set=9 and wr_en=1, wr_id=9 -> R9 updated, pending[9] stays 1,
//      pend_cnt unchanged.
//   6. Set pending on R1..R15 -> pend_cnt=15. Drop rst_n mid-cycle -> pend_cnt=0 and all busy=0
//      at once, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - 16x DATA_W register file, 2R/1W, with write bypass and pending-write scoreboard
module rf_id_decoder (
  input  logic [3:0]  id_i,
  input  logic        en_i,
  output logic [15:0] wl_o
);
  assign wl_o = en_i ? (16'd1 << id_i) : 16'd0;
endmodule

module reg_file_scoreboard #(
  parameter int DATA_W      = 16,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        src_id1,
  input  logic [3:0]        src_id2,
  input  logic              wr_en,
  input  logic [3:0]        wr_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pend_set,
  input  logic [3:0]        pend_id,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2,
  output logic              src_busy1,
  output logic              src_busy2,
  output logic [4:0]        pend_cnt
);
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];
  logic [15:0]       pending_q, pending_d;
  logic [4:0]        pend_cnt_q, pend_cnt_d;

  logic [15:0] rd_wl1, rd_wl2, wr_wl, set_wl;
  logic        wr_eff, set_eff, r0_src1, r0_src2;
  logic        byp1, byp2, wr_hit1, wr_hit2;
  logic [DATA_W-1:0] rd1, rd2;

  // R0 writes and pending marks are dropped before they reach the wordlines
  assign wr_eff  = wr_en    & ~(ZERO_REG_EN && (wr_id   == 4'd0));
  assign set_eff = pend_set & ~(ZERO_REG_EN && (pend_id == 4'd0));

  rf_id_decoder u_dec_rd1 (.id_i(src_id1), .en_i(1'b1),    .wl_o(rd_wl1));
  rf_id_decoder u_dec_rd2 (.id_i(src_id2), .en_i(1'b1),    .wl_o(rd_wl2));
  rf_id_decoder u_dec_wr  (.id_i(wr_id),   .en_i(wr_eff),  .wl_o(wr_wl));
  rf_id_decoder u_dec_set (.id_i(pend_id), .en_i(set_eff), .wl_o(set_wl));

  always_comb begin
    regs_d     = regs_q;
    pending_d  = pending_q;
    pend_cnt_d = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (wr_wl[i]) regs_d[i] = wr_data;
      // a new producer on the same edge supersedes the retiring one
      pending_d[i] = (pending_q[i] & ~wr_wl[i]) | set_wl[i];
      pend_cnt_d   = pend_cnt_d + {4'd0, pending_d[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < 16; i++) begin
      rd1 = rd1 | (regs_q[i] & {DATA_W{rd_wl1[i]}});
      rd2 = rd2 | (regs_q[i] & {DATA_W{rd_wl2[i]}});
    end
  end

  assign r0_src1 = ZERO_REG_EN && (src_id1 == 4'd0);
  assign r0_src2 = ZERO_REG_EN && (src_id2 == 4'd0);
  assign wr_hit1 = wr_en & (wr_id == src_id1);
  assign wr_hit2 = wr_en & (wr_id == src_id2);
  assign byp1    = wr_eff & (wr_id == src_id1);
  assign byp2    = wr_eff & (wr_id == src_id2);

  assign src_data1 = r0_src1 ? '0 : (byp1 ? wr_data : rd1);
  assign src_data2 = r0_src2 ? '0 : (byp2 ? wr_data : rd2);
  assign src_busy1 = (|(rd_wl1 & pending_q)) & ~wr_hit1;
  assign src_busy2 = (|(rd_wl2 & pending_q)) & ~wr_hit2;
  assign pend_cnt  = pend_cnt_q;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - directed self-checking bench for reg_file_scoreboard
module tb_reg_file_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_id1, src_id2, wr_id, pend_id;
  logic        wr_en, pend_set;
  logic [15:0] wr_data;
  logic [15:0] src_data1, src_data2;
  logic        src_busy1, src_busy2;
  logic [4:0]  pend_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_scoreboard #(.DATA_W(16), .ZERO_REG_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_id1(src_id1), .src_id2(src_id2),
    .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .pend_set(pend_set), .pend_id(pend_id),
    .src_data1(src_data1), .src_data2(src_data2),
    .src_busy1(src_busy1), .src_busy2(src_busy2),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; pend_set = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; src_id1 = 4'd0; src_id2 = 4'd0; wr_en = 1'b0; wr_id = 4'd0;
    wr_data = 16'h0; pend_set = 1'b0; pend_id = 4'd0;
    tick(); tick();
    check("rst_cnt_in_reset", 32'(pend_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: zeroed state on every register
    for (int i = 1; i < 16; i++) begin
      src_id1 = 4'(i); src_id2 = 4'(16 - i);
      #1;
      check("rst_data1", 32'(src_data1), 32'd0);
      check("rst_data2", 32'(src_data2), 32'd0);
      check("rst_busy",  32'({src_busy1, src_busy2}), 32'd0);
    end
    check("rst_cnt", 32'(pend_cnt), 32'd0);

    // 2: write then read; same-cycle bypass; both ports same register
    wr_en = 1'b1; wr_id = 4'd5; wr_data = 16'hBEEF;
    tick(); idle();
    src_id1 = 4'd5; src_id2 = 4'd5; #1;
    check("rd_r5_p1", 32'(src_data1), 32'hBEEF);
    check("rd_r5_p2", 32'(src_data2), 32'hBEEF);
    wr_en = 1'b1; wr_id = 4'd7; wr_data = 16'h1234; src_id2 = 4'd7; #1;
    check("byp_r7", 32'(src_data2), 32'h1234);
    check("byp_r5_unaff", 32'(src_data1), 32'hBEEF);
    tick(); idle(); #1;
    check("rd_r7_stored", 32'(src_data2), 32'h1234);

    // 3: R0 is hardwired zero and never pending
    wr_en = 1'b1; wr_id = 4'd0; wr_data = 16'hFFFF; src_id1 = 4'd0; #1;
    check("r0_no_bypass", 32'(src_data1), 32'd0);
    tick(); idle(); #1;
    check("r0_read", 32'(src_data1), 32'd0);
    pend_set = 1'b1; pend_id = 4'd0;
    tick(); idle(); #1;
    check("r0_pend_cnt", 32'(pend_cnt), 32'd0);
    check("r0_busy", 32'(src_busy1), 32'd0);

    // 4: RAW hazard on R3, resolved by the write-back bypass
    pend_set = 1'b1; pend_id = 4'd3;
    tick(); idle();
    src_id1 = 4'd3; src_id2 = 4'd3; #1;
    check("r3_busy1", 32'(src_busy1), 32'd1);
    check("r3_busy2", 32'(src_busy2), 32'd1);
    check("r3_cnt1", 32'(pend_cnt), 32'd1);
    wr_en = 1'b1; wr_id = 4'd3; wr_data = 16'h00AA; #1;
    check("r3_wb_busy", 32'(src_busy1), 32'd0);
    check("r3_wb_data", 32'(src_data1), 32'h00AA);
    tick(); idle(); #1;
    check("r3_cnt0", 32'(pend_cnt), 32'd0);
    check("r3_busy_after", 32'(src_busy1), 32'd0);
    check("r3_data_after", 32'(src_data1), 32'h00AA);

    // 5: same-edge set and clear on R9; clear of a non-pending register
    pend_set = 1'b1; pend_id = 4'd9;
    tick(); idle(); #1;
    check("r9_cnt1", 32'(pend_cnt), 32'd1);
    pend_set = 1'b1; pend_id = 4'd9; wr_en = 1'b1; wr_id = 4'd9; wr_data = 16'h5A5A;
    tick(); idle();
    src_id1 = 4'd9; #1;
    check("r9_data", 32'(src_data1), 32'h5A5A);
    check("r9_still_busy", 32'(src_busy1), 32'd1);
    check("r9_cnt_same", 32'(pend_cnt), 32'd1);
    wr_en = 1'b1; wr_id = 4'd4; wr_data = 16'h0001;
    tick(); idle(); #1;
    check("clr_nonpend_cnt", 32'(pend_cnt), 32'd1);
    wr_en = 1'b1; wr_id = 4'd9; wr_data = 16'h0002;
    tick(); idle(); #1;
    check("r9_cleared_cnt", 32'(pend_cnt), 32'd0);

    // 6: fill R1..R15, then asynchronous reset mid-cycle
    for (int i = 1; i < 16; i++) begin
      pend_set = 1'b1; pend_id = 4'(i);
      tick();
    end
    idle();
    src_id1 = 4'd5; src_id2 = 4'd15; #1;
    check("fill_cnt15", 32'(pend_cnt), 32'd15);
    check("fill_busy", 32'({src_busy1, src_busy2}), 32'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_cnt", 32'(pend_cnt), 32'd0);
    check("async_busy", 32'({src_busy1, src_busy2}), 32'd0);
    check("async_data", 32'(src_data1), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
